// File: rtl/bus_xfer_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bus_xfer_ctrl_if                                           |
// | Description : Request and bus-enable signal bundle for bus_xfer_ctrl.    |
// |               master : control unit side (issues transfer requests).     |
// |               slave  : sequencer side (bus_xfer_ctrl).                   |
// | Signals     : req_valid  master->slave  request presented                |
// |               req_ready  slave->master  request FIFO not full            |
// |               req_src    master->slave  4-bit source register code       |
// |               req_dst    master->slave  11-bit destination mask          |
// |               rd_en      slave->master  one-hot source read enables      |
// |               wr_en      slave->master  destination load enables         |
// |               xfer_done  slave->master  pulse in the write cycle         |
// |               busy       slave->master  sequencer active or FIFO pending |
// |               err        slave->master  illegal-request pulse            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface bus_xfer_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_src;
  logic [10:0] req_dst;
  logic [10:0] rd_en;
  logic [10:0] wr_en;
  logic        xfer_done;
  logic        busy;
  logic        err;

  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, rd_en, wr_en, xfer_done, busy, err
  );

  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, rd_en, wr_en, xfer_done, busy, err
  );
endinterface : bus_xfer_ctrl_if
`default_nettype wire

// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bus_xfer_ctrl                                              |
// | Description : Bus transfer sequencer. Queues register-to-register        |
// |               requests in a DEPTH-entry FIFO, then for each request      |
// |               drives the one-hot source read enable for two cycles       |
// |               (DRIVE, WRITE) and pulses the destination load enables in  |
// |               the second (WRITE) cycle. All outputs are registered.      |
// | Parameters  : DEPTH  request FIFO entries (power of two, >= 2)           |
// |               PTR_W  log2(DEPTH)                                         |
// | Ports       : clk    system clock, rising edge                           |
// |               rst_n  asynchronous active-low reset                       |
// |               bus    bus_xfer_ctrl_if.slave (request + enable bundle)    |
// | Options     : BUS_XFER_CHECK_EN  when defined, popped entries with an    |
// |               illegal source, empty/read-only/self destination are       |
// |               discarded and flagged on err for one cycle.                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module bus_xfer_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  bus_xfer_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  // IM (bit 5) is read-only and must never receive a load enable.
  localparam logic [10:0]    RO_MASK  = 11'h020;

  // Source code -> one-hot read enable; codes 11..15 select nothing so the
  // bus keeps its previous value.
  function automatic logic [10:0] decode_src(input logic [3:0] s);
    logic [10:0] oh;
    oh = '0;
    if (s <= 4'd10) begin
      oh = 11'b1 << s;
    end
    return oh;
  endfunction

`ifdef BUS_XFER_CHECK_EN
  // A source writing to itself is flagged via the decoded source overlapping
  // the destination mask; illegal sources decode to zero but are caught first.
  function automatic logic is_illegal(input logic [3:0] s, input logic [10:0] d);
    logic bad;
    bad = 1'b0;
    if (s > 4'd10)                  bad = 1'b1;
    if (d == '0)                    bad = 1'b1;
    if ((d & RO_MASK) != '0)        bad = 1'b1;
    if ((d & decode_src(s)) != '0)  bad = 1'b1;
    return bad;
  endfunction
`endif

  // --------------------------------------------------------------------------
  // Request FIFO
  // --------------------------------------------------------------------------
  logic [3:0]       src_mem [DEPTH];
  logic [10:0]      dst_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             push;
  logic             pop;
  logic [3:0]       head_src;
  logic [10:0]      head_dst;

  // FSM and holding registers
  state_t           state_q, state_d;
  logic [3:0]       src_q, src_d;
  logic [10:0]      dst_q, dst_d;

  // Registered outputs
  logic             req_ready_q, req_ready_d;
  logic [10:0]      rd_en_q, rd_en_d;
  logic [10:0]      wr_en_q, wr_en_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // req_ready is a registered "not full" flag, so a full FIFO refuses a push
  // even on an edge where an entry is popped.
  assign push     = bus.req_valid && req_ready_q;
  assign head_src = src_mem[rd_ptr_q];
  assign head_dst = dst_mem[rd_ptr_q];

  // Storage has no reset; validity is tracked entirely by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wr_ptr_q] <= bus.req_src;
      dst_mem[wr_ptr_q] <= bus.req_dst;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          src_d   = head_src;
          dst_d   = head_dst;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Chain straight into the next transfer so rd_en switches sources
        // with no idle gap.
        if (count_q != '0) begin
          pop     = 1'b1;
          src_d   = head_src;
          dst_d   = head_dst;
          state_d = S_DRIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef BUS_XFER_CHECK_EN
    // An illegal entry is consumed but parks the FSM in IDLE; the next entry
    // is considered on the following edge.
    if (pop && is_illegal(head_src, head_dst)) begin
      state_d = S_IDLE;
    end
`endif

    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    // Outputs are computed from next state so they can be registered and
    // still line up with the state they describe.
    req_ready_d = (count_d != FULL_CNT);
    busy_d      = (state_d != S_IDLE) || (count_d != '0);
    rd_en_d     = ((state_d == S_DRIVE) || (state_d == S_WRITE)) ? decode_src(src_d) : '0;
    wr_en_d     = (state_d == S_WRITE) ? (dst_d & ~RO_MASK) : '0;
    done_d      = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rd_en_q     <= '0;
      wr_en_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      done_q      <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Error flag
  // --------------------------------------------------------------------------
`ifdef BUS_XFER_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = pop && is_illegal(head_src, head_dst);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.xfer_done = done_q;
  assign bus.busy      = busy_q;

endmodule : bus_xfer_ctrl
`default_nettype wire

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

Bus transfer sequencer for the core datapath. It accepts queued register-to-register transfer requests from the control unit. For each request it drives the one-hot source read enables that select a register onto the shared 16-bit bus, then pulses the destination write enables so the bus value is latched. It is the write-side counterpart of the bus source multiplexer: it generates that multiplexer's `*_read_en` inputs and the load enables of every bus-connected register.

## Interface
Parameters:
- `DEPTH`, 4: request FIFO entries; must be a power of two, at least 2.
- `PTR_W`, 2: FIFO pointer width, equal to log2(`DEPTH`).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  a transfer request is presented.
- `req_ready`  out  1  FIFO not full; a request is accepted on an edge where `req_valid` and `req_ready` are both high.
- `req_src`  in  4  source code: 0 PC, 1 AR, 2 AC, 3 R, 4 DM, 5 IM, 6 DR, 7 A, 8 B, 9 C, 10 D; codes 11–15 are illegal.
- `req_dst`  in  11  destination mask; bit order matches the source codes; bit 5 (IM) is read-only.
- `rd_en`  out  11  one-hot source read enables, bit order as `req_src`.
- `wr_en`  out  11  destination load enables; bit 5 is always 0.
- `xfer_done`  out  1  one-cycle pulse in the cycle `wr_en` is asserted.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.
- `err`  out  1  illegal-request pulse; tied 0 unless `BUS_XFER_CHECK_EN` is defined.

## Operation
- Requests `{src, dst}` are written into a `DEPTH`-entry FIFO with wrap-around pointers and an occupancy counter.
- `req_ready` = FIFO not full.
- When full, `req_ready` is low even if a pop occurs on the same edge. There is no same-cycle pass-through.
- Push and pop on the same edge leave the occupancy unchanged.
- The FSM has three states: IDLE, DRIVE, WRITE.
  - IDLE → DRIVE when the FIFO is non-empty. The head entry is popped into holding registers.
  - DRIVE → WRITE unconditionally.
  - WRITE → DRIVE if the FIFO is non-empty, popping the next entry. Otherwise WRITE → IDLE.
- All outputs are registered.
  - `rd_en` = decode(src) during DRIVE and WRITE, else 0.
  - `wr_en` = dst with bit 5 masked, during WRITE only.
  - `xfer_done` = 1 during WRITE.
- The source code is decoded onto exactly one `rd_en` bit. Codes 11–15 decode to all-zero, so the bus holds its previous value.
- Reset (asynchronous, any time, including mid-transfer):
  - FSM returns to IDLE and the FIFO is flushed.
  - `rd_en`, `wr_en`, `xfer_done`, `busy`, and `err` all go to 0.
  - `req_ready` goes to 1.
  - The interrupted transfer is lost; no partial `wr_en` is issued.

## Timing
- Cycle n is the interval following rising edge n.
- With the FIFO empty and the FSM in IDLE, a request is accepted at edge 0:
  - `busy` = 1 in cycle 0.
  - `rd_en` is asserted in cycles 1–2.
  - `wr_en` and `xfer_done` are asserted in cycle 2.
  - The destination captures the bus at edge 3.
- Back-to-back throughput is one transfer per 2 cycles. `rd_en` switches directly to the next source in cycle 3 with no idle gap.
- `rd_en` is stable for a full cycle before `wr_en` rises, so the bus settles before the write.
- `busy` falls in the cycle after the last WRITE if no request was accepted meanwhile.

## Configuration
- `BUS_XFER_CHECK_EN` defined:
  - A popped entry is illegal if src > 10, dst == 0, dst[5] == 1, or dst[src] == 1.
  - An illegal entry enters neither DRIVE nor WRITE; it is discarded in the pop cycle.
  - `err` pulses for 1 cycle (the cycle after the pop edge).
  - The FSM evaluates the next entry on the following edge.
- `BUS_XFER_CHECK_EN` undefined:
  - No checking; every entry runs DRIVE/WRITE.
  - Illegal src gives `rd_en` = 0; dst[5] is masked.
  - `err` is constant 0.

## Test plan
- Single transfer: src = 2 (AC), dst = 11'h080 (A) at edge 0 → `rd_en` = 11'h004 in cycles 1–2; `wr_en` = 11'h080 and `xfer_done` = 1 in cycle 2; `busy` = 0 from cycle 3.
- Back-to-back: 4 requests pushed on consecutive edges (src 0, 1, 7, 8) → `rd_en` sequence 001/001/002/002/080/080/100/100 over cycles 1–8; `req_ready` never drops with `DEPTH` = 4.
- FIFO full: 6 requests pushed with `DEPTH` = 4 → `req_ready` low after the 4th push plus drain state; no request is lost or duplicated; all 6 complete in order.
- Reset mid-op: `rst_n` asserted during WRITE → `wr_en` = 0 immediately; after release, `req_ready` = 1, `busy` = 0, and no stale transfer executes.
- Illegal request: src = 12, dst = 11'h020 → with `BUS_XFER_CHECK_EN`: `err` pulses once and `rd_en`/`wr_en` stay 0. Without it: `rd_en` = 0 in DRIVE/WRITE, `wr_en` = 0, `xfer_done` pulses.
